mc_datapath_hs: RTL and testbench
=================================

MC_DATAPATH_HS -- requirements
Module: mc_datapath_hs

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter NREGS, default 32, register count (16 = RV32E, or 32).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports PCWrite, AdrSrc, IRWrite, RegWrite, MemReq, MemWrite  in  1 each  controller strobes.
REQ-007 SHALL have ports ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[2:0], ALUControl[3:0]  in  controller selects.
REQ-008 SHALL have ports Zero, CarryOut, Overflow, Sign  out  1 each  ALU flags, combinational from the current ALU operands.
REQ-009 SHALL have port Instr  out  32  instruction register.
REQ-010 SHALL have port Busy  out  1  memory transaction in progress; the controller holds its state while Busy=1.
REQ-011 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out XLEN, mem_we out 1, mem_wdata out XLEN  memory request channel.
REQ-012 SHALL have ports mem_rsp_valid in 1, mem_rdata in XLEN  memory read-response channel.

Function
REQ-013 SHALL hold non-architectural registers PC, OldPC, Instr, Data, A, WriteData and ALUOut, with the same roles as in the current multicycle datapath.
REQ-014 SHALL run a port FSM with states M_IDLE, M_REQ and M_RSP; Busy = (state != M_IDLE).
REQ-015 SHALL, when state is M_IDLE and MemReq=1: latch Adr (PC if AdrSrc=0, Result if AdrSrc=1) into mem_addr, latch MemWrite into mem_we, latch WriteData into mem_wdata, latch IRWrite into a pending-IR flag, and go to M_REQ.
REQ-016 SHALL hold mem_req_valid=1 and keep mem_addr, mem_we and mem_wdata stable in M_REQ until mem_req_ready=1.
REQ-017 SHALL, on a request handshake, go to M_IDLE for a write and to M_RSP for a read.
REQ-018 SHALL, in M_RSP with mem_rsp_valid=1, load mem_rdata into Data, also load it into Instr (with OldPC<=PC) when the pending-IR flag is set, and go to M_IDLE.
REQ-019 SHALL ignore mem_rsp_valid outside M_RSP; a response SHALL NOT be accepted in the same cycle as its request handshake.
REQ-020 SHALL ignore MemReq while Busy=1.
REQ-021 SHALL gate PCWrite, RegWrite, IRWrite and the A, WriteData and ALUOut updates with ~Busy.
REQ-022 SHALL, in the M_IDLE+MemReq cycle, suppress IRWrite's direct Instr load; Instr is loaded only by the response.
REQ-023 SHALL read register x0 as 0, and SHALL return 0 for indices >= NREGS; writes to x0 or to indices >= NREGS SHALL be dropped.
REQ-024 SHALL make register-file reads combinational; a write SHALL be visible on the cycle after it.
REQ-025 SHALL sign-extend immediates from Instr[31:7] per ImmSrc to XLEN bits.
REQ-026 SHALL compute ALU arithmetic modulo 2^XLEN, with CarryOut and Overflow defined on the XLEN-bit result.

Reset
REQ-027 SHALL, on rst_n=0, immediately set: state=M_IDLE; PC=RESET_PC; every other register and all register-file entries=0; mem_req_valid=0; Busy=0.
REQ-028 SHALL abandon any in-flight transaction on reset; a late mem_rsp_valid after reset SHALL be ignored.

Structure
REQ-029 SHALL place the port-state enum and the ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings in shared package mc_pkg.
REQ-030 SHALL implement the handshake FSM in sub-module mc_mem_port; the ALU, extend and register-file blocks SHALL be parametrised by XLEN and NREGS.

Verification
REQ-031 SHALL cover fetch: RESET_PC=0x100, MemReq=1, IRWrite=1, AdrSrc=0; ready after 2 cycles, rsp_valid 3 cycles later with 0x00500093 -> mem_addr=0x100 throughout, Busy=1 for 6 cycles, then Instr=0x00500093 and OldPC=0x100.
REQ-032 SHALL cover store: MemWrite=1, WriteData=0xDEADBEEF, ready=1 immediately -> one cycle with mem_req_valid=1 and mem_we=1, then M_IDLE; no response is awaited.
REQ-033 SHALL cover the stall gate: RegWrite=1 and PCWrite=1 held while Busy=1 -> registers and PC unchanged until Busy falls.
REQ-034 SHALL cover RV32E: NREGS=16, write x20=5 then read x20 -> 0; write x0=7 then read x0 -> 0.
REQ-035 SHALL cover reset mid-read: rst_n low in M_RSP, then rsp_valid pulse -> Data=0, state=M_IDLE, PC=RESET_PC.
REQ-036 SHALL cover XLEN=64: ADD of 0xFFFF_FFFF_FFFF_FFFF and 1 -> result 0, Zero=1, CarryOut=1, Overflow=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the handshaked multicycle datapath: port FSM states,
// ALU operations and the controller mux selects.
package mc_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_REQ  = 2'd1,
        M_RSP  = 2'd2
    } mport_state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } alu_op_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] SRCB_ZERO  = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_mem_port.sv
// Valid/ready memory port: captures one request, holds it until accepted,
// then waits for the read response (writes complete on the handshake).
module mc_mem_port
    import mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            we,
    input  logic            ir,
    input  logic [XLEN-1:0] adr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            rsp_take,
    output logic            ir_pend,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid
);

    mport_state_t state, state_nxt;
    logic launch;

    assign launch = (state == M_IDLE) && req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= M_IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            ir_pend   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                mem_addr  <= adr;
                mem_we    <= we;
                mem_wdata <= wdata;
                ir_pend   <= ir;
            end
        end
    end

    // Response is only looked at from M_RSP, so it can never be taken in
    // the same cycle as the request handshake.
    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        rsp_take      = 1'b0;
        case (state)
            M_IDLE: if (req) state_nxt = M_REQ;
            M_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = mem_we ? M_IDLE : M_RSP;
            end
            M_RSP: begin
                rsp_take = mem_rsp_valid;
                if (mem_rsp_valid) state_nxt = M_IDLE;
            end
            default: state_nxt = M_IDLE;
        endcase
    end

    assign busy = (state != M_IDLE);

endmodule

// File: rtl/mc_datapath_hs.sv
// Multicycle RISC-V datapath with a stalling valid/ready memory port.
// While the port is busy every architectural update is frozen.
module mc_datapath_hs
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCWrite,
    input  logic            AdrSrc,
    input  logic            IRWrite,
    input  logic            RegWrite,
    input  logic            MemReq,
    input  logic            MemWrite,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [2:0]      ImmSrc,
    input  logic [3:0]      ALUControl,
    output logic            Zero,
    output logic            CarryOut,
    output logic            Overflow,
    output logic            Sign,
    output logic [31:0]     Instr,
    output logic            Busy,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int RW  = $clog2(NREGS);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] pc, old_pc, data, a_reg, write_data, alu_out;
    logic [31:0]     instr;
    logic [XLEN-1:0] rf [NREGS];

    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result, adr;
    logic [31:0]     imm32;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] b_op;
    logic            sub, ovf_raw, busy, rsp_take, ir_pend;
    alu_op_t         op;

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    // x0 and indices beyond the implemented file read as zero and drop writes.
    function automatic logic in_rf(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NREGS);
    endfunction

    assign rd1 = in_rf(rs1) ? rf[rs1[RW-1:0]] : '0;
    assign rd2 = in_rf(rs2) ? rf[rs2[RW-1:0]] : '0;

    always_comb begin
        imm32 = '0;
        case (ImmSrc)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    always_comb begin
        case (ALUSrcA)
            SRCA_PC:    src_a = pc;
            SRCA_OLDPC: src_a = old_pc;
            SRCA_A:     src_a = a_reg;
            default:    src_a = '0;
        endcase
        case (ALUSrcB)
            SRCB_WD:   src_b = write_data;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = XLEN'(4);
            default:   src_b = '0;
        endcase
    end

    // One adder serves ADD, SUB and both compares; CarryOut on SUB means no borrow.
    always_comb begin
        op      = alu_op_t'(ALUControl);
        sub     = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
        b_op    = sub ? ~src_b : src_b;
        sum     = {1'b0, src_a} + {1'b0, b_op} + {{XLEN{1'b0}}, sub};
        ovf_raw = (src_a[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
        case (op)
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf_raw};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, ~sum[XLEN]};
            ALU_SLL:  alu_result = src_a << src_b[SHW-1:0];
            ALU_SRL:  alu_result = src_a >> src_b[SHW-1:0];
            ALU_SRA:  alu_result = $signed(src_a) >>> src_b[SHW-1:0];
            default:  alu_result = sum[XLEN-1:0];
        endcase
    end

    assign Zero     = (alu_result == '0);
    assign Sign     = alu_result[XLEN-1];
    assign CarryOut = ((op == ALU_ADD) || (op == ALU_SUB)) && sum[XLEN];
    assign Overflow = ((op == ALU_ADD) || (op == ALU_SUB)) && ovf_raw;

    always_comb begin
        case (ResultSrc)
            RES_ALUOUT: result = alu_out;
            RES_DATA:   result = data;
            RES_ALU:    result = alu_result;
            default:    result = imm_ext;
        endcase
    end

    assign adr = AdrSrc ? result : pc;

    mc_mem_port #(.XLEN(XLEN)) u_port (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (MemReq),
        .we            (MemWrite),
        .ir            (IRWrite),
        .adr           (adr),
        .wdata         (write_data),
        .busy          (busy),
        .rsp_take      (rsp_take),
        .ir_pend       (ir_pend),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            old_pc     <= '0;
            instr      <= '0;
            data       <= '0;
            a_reg      <= '0;
            write_data <= '0;
            alu_out    <= '0;
        end else begin
            if (PCWrite && !busy) pc <= result;
            if (!busy) begin
                a_reg      <= rd1;
                write_data <= rd2;
                alu_out    <= alu_result;
            end
            // A fetch fills Instr from its response; the direct IRWrite load
            // only applies when no request is being launched.
            if (rsp_take) begin
                data <= mem_rdata;
                if (ir_pend) begin
                    instr  <= mem_rdata[31:0];
                    old_pc <= pc;
                end
            end else if (IRWrite && !busy && !MemReq) begin
                instr  <= data[31:0];
                old_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (RegWrite && !busy && in_rf(rd)) begin
            rf[rd[RW-1:0]] <= result;
        end
    end

    assign Instr = instr;
    assign Busy  = busy;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench: three datapath instances (RV32I, RV32E, XLEN=64) share one
// controller/memory stimulus; outputs are checked against hand-computed values.
module tb_mc_datapath_hs;

    logic        clk, rst_n;
    logic        PCWrite, AdrSrc, IRWrite, RegWrite, MemReq, MemWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        mem_req_ready, mem_rsp_valid;
    logic [63:0] mem_rdata;

    logic        m_zero, m_carry, m_ovf, m_sign, m_busy, m_valid, m_we;
    logic [31:0] m_instr, m_addr, m_wdata;
    logic        e_zero, e_carry, e_ovf, e_sign, e_busy, e_valid, e_we;
    logic [31:0] e_instr, e_addr, e_wdata;
    logic        w_zero, w_carry, w_ovf, w_sign, w_busy, w_valid, w_we;
    logic [31:0] w_instr;
    logic [63:0] w_addr, w_wdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic hold_wr = 1'b0;

    mc_datapath_hs #(.XLEN(32), .NREGS(32), .RESET_PC(32'h100)) u_dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemReq(MemReq), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .Zero(m_zero), .CarryOut(m_carry), .Overflow(m_ovf), .Sign(m_sign), .Instr(m_instr),
        .Busy(m_busy), .mem_req_valid(m_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(m_addr), .mem_we(m_we), .mem_wdata(m_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0])
    );

    mc_datapath_hs #(.XLEN(32), .NREGS(16), .RESET_PC(32'h100)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemReq(MemReq), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .Zero(e_zero), .CarryOut(e_carry), .Overflow(e_ovf), .Sign(e_sign), .Instr(e_instr),
        .Busy(e_busy), .mem_req_valid(e_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(e_addr), .mem_we(e_we), .mem_wdata(e_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0])
    );

    mc_datapath_hs #(.XLEN(64), .NREGS(32), .RESET_PC(64'h100)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemReq(MemReq), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .Zero(w_zero), .CarryOut(w_carry), .Overflow(w_ovf), .Sign(w_sign), .Instr(w_instr),
        .Busy(w_busy), .mem_req_valid(w_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(w_addr), .mem_we(w_we), .mem_wdata(w_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        PCWrite = 0; AdrSrc = 0; IRWrite = 0; RegWrite = 0; MemReq = 0; MemWrite = 0;
        ResultSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ImmSrc = 0; ALUControl = 0;
    endtask

    // Launch one transaction; bogus responses are offered during the request
    // phase (including the handshake cycle) and must be ignored.
    task automatic mem_txn(input string tag, input logic we, input logic ir, input logic adr,
                           input int rdy_wait, input int rsp_wait, input logic [63:0] rdata,
                           input logic [31:0] exp_addr, input int exp_busy);
        int busy_n = 0, valid_n = 0, we_n = 0, addr_bad = 0;
        MemReq = 1; MemWrite = we; IRWrite = ir; AdrSrc = adr;
        tick();
        MemReq = 0; MemWrite = 0; IRWrite = 0;
        RegWrite = hold_wr; PCWrite = hold_wr;
        for (int i = 0; i <= rdy_wait; i++) begin
            mem_req_ready = (i == rdy_wait);
            mem_rsp_valid = 1'b1;
            mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clk);
            busy_n += int'(m_busy);
            if (m_valid) begin
                valid_n++;
                we_n += int'(m_we);
                if (m_addr !== exp_addr) addr_bad++;
            end
            tick();
        end
        mem_req_ready = 0; mem_rsp_valid = 0;
        if (!we) begin
            for (int i = 0; i <= rsp_wait; i++) begin
                mem_rsp_valid = (i == rsp_wait);
                mem_rdata     = (i == rsp_wait) ? rdata : 64'hBAD1_BAD1_BAD1_BAD1;
                @(negedge clk);
                busy_n += int'(m_busy);
                if (m_valid) valid_n++;
                tick();
            end
        end
        mem_rsp_valid = 0; RegWrite = 0; PCWrite = 0; AdrSrc = 0;
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        chk({tag, "_valid_cycles"}, 64'(valid_n), 64'(rdy_wait + 1));
        chk({tag, "_we_cycles"}, 64'(we_n), we ? 64'(rdy_wait + 1) : 64'd0);
        chk({tag, "_addr_bad"}, 64'(addr_bad), 64'd0);
        chk({tag, "_busy_after"}, 64'(m_busy), 64'd0);
    endtask

    // Fetch an instruction whose rd/rs1/rs2 all name the target, load the
    // value through Data, write it back, then let A/WriteData refresh.
    task automatic load_reg(input string tag, input logic [31:0] iw, input logic [63:0] val);
        mem_txn({tag, "_f"}, 1'b0, 1'b1, 1'b0, 0, 0, {32'h0, iw}, 32'h104, 2);
        chk({tag, "_instr"}, 64'(m_instr), 64'(iw));
        mem_txn({tag, "_d"}, 1'b0, 1'b0, 1'b0, 0, 0, val, 32'h104, 2);
        ResultSrc = 2'b01; RegWrite = 1;
        tick();
        RegWrite = 0; ResultSrc = 0;
        tick();
    endtask

    initial begin
        rst_n = 0; clr_ctl();
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
        #12;
        chk("rst_busy", 64'(m_busy), 0);
        chk("rst_valid", 64'(m_valid), 0);
        chk("rst_instr", 64'(m_instr), 0);
        chk("rst_addr", 64'(m_addr), 0);
        chk("rst_zero", 64'(m_zero), 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // fetch: ready after 2 waits, response 3 cycles after handshake
        mem_txn("fetch", 1'b0, 1'b1, 1'b0, 2, 2, 64'h0050_0093, 32'h100, 6);
        chk("fetch_instr", 64'(m_instr), 64'h0050_0093);

        // OldPC read out through Result -> store address
        ALUSrcA = 2'b01; ALUSrcB = 2'b11; ResultSrc = 2'b10;
        mem_txn("oldpc", 1'b1, 1'b0, 1'b1, 0, 0, '0, 32'h100, 1);
        clr_ctl();

        // PC <= PC + 4
        ALUSrcA = 2'b00; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1;
        tick();
        clr_ctl();

        // x1 <= 0xDEADBEEF, then store it with an immediate ready
        load_reg("x1", 32'h0010_8093, 64'h0000_0000_DEAD_BEEF);
        mem_txn("store", 1'b1, 1'b0, 1'b0, 0, 0, '0, 32'h104, 1);
        chk("store_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
        chk("store_we", 64'(m_we), 1);
        chk("store_instr_kept", 64'(m_instr), 64'h0010_8093);

        // stall gate: RegWrite/PCWrite held with Result = PC+4 during a read
        ALUSrcA = 2'b00; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        hold_wr = 1'b1;
        mem_txn("stall", 1'b0, 1'b0, 1'b0, 1, 1, 64'h1234_5678, 32'h104, 4);
        hold_wr = 1'b0;
        clr_ctl();
        tick();
        mem_txn("stall_chk", 1'b1, 1'b0, 1'b0, 0, 0, '0, 32'h104, 1);
        chk("stall_x1", 64'(m_wdata), 64'hDEAD_BEEF);

        // x20 exists only in the 32-register instance; x0 is never written
        load_reg("x20", 32'h014A_0A13, 64'd5);
        mem_txn("x20_rd", 1'b1, 1'b0, 1'b0, 0, 0, '0, 32'h104, 1);
        chk("x20_rv32i", 64'(m_wdata), 64'd5);
        chk("x20_rv32e", 64'(e_wdata), 64'd0);
        load_reg("x0", 32'h0000_0013, 64'd7);
        mem_txn("x0_rd", 1'b1, 1'b0, 1'b0, 0, 0, '0, 32'h104, 1);
        chk("x0_rv32i", 64'(m_wdata), 64'd0);
        chk("x0_rv32e", 64'(e_wdata), 64'd0);

        // XLEN=64: all-ones + 1 wraps to zero with carry, no overflow
        load_reg("ones", 32'h0010_8093, 64'hFFFF_FFFF_FFFF_FFFF);
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 3'b000; ALUControl = 4'h0;
        #1;
        chk("w_add_zero", 64'(w_zero), 1);
        chk("w_add_carry", 64'(w_carry), 1);
        chk("w_add_ovf", 64'(w_ovf), 0);
        chk("w_add_sign", 64'(w_sign), 0);
        chk("m_add_zero", 64'(m_zero), 1);
        chk("m_add_carry", 64'(m_carry), 1);
        ResultSrc = 2'b10;
        mem_txn("w_sum", 1'b1, 1'b0, 1'b1, 0, 0, '0, 32'h0, 1);
        chk("w_sum_addr", w_addr, 64'h0);
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = 4'h1;
        #1;
        chk("w_sub_zero", 64'(w_zero), 0);
        chk("w_sub_carry", 64'(w_carry), 1);
        chk("w_sub_sign", 64'(w_sign), 1);
        ALUSrcA = 2'b11;
        #1;
        chk("m_borrow_carry", 64'(m_carry), 0);
        chk("m_borrow_sign", 64'(m_sign), 1);
        chk("m_borrow_ovf", 64'(m_ovf), 0);
        clr_ctl();
        tick();

        // reset while waiting for a fetch response; late response ignored
        MemReq = 1; IRWrite = 1;
        tick();
        MemReq = 0; IRWrite = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        @(negedge clk);
        chk("mid_busy_rsp", 64'(m_busy), 1);
        rst_n = 0;
        #1;
        chk("mid_busy_rst", 64'(m_busy), 0);
        chk("mid_valid_rst", 64'(m_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1; mem_rsp_valid = 1; mem_rdata = 64'hCAFE_F00D;
        tick();
        mem_rsp_valid = 0;
        chk("late_busy", 64'(m_busy), 0);
        chk("late_instr", 64'(m_instr), 0);
        ResultSrc = 2'b01;
        mem_txn("late_data", 1'b1, 1'b0, 1'b1, 0, 0, '0, 32'h0, 1);
        ResultSrc = 2'b00;
        mem_txn("late_pc", 1'b1, 1'b0, 1'b0, 0, 0, '0, 32'h100, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
